// File: rtl/pipeline_mem.sv
// Memory stage: turns an EX result into an optional aligned dmem access and hands one
// writeback record at a time to WB. Sub-word loads are extracted and extended here.
module pipeline_mem #(
   parameter int ADDR_WIDTH = 64,
   parameter int DATA_WIDTH = 64
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  ex_valid,
   output logic                  ready,
   input  logic [DATA_WIDTH-1:0] ex_res,
   input  logic [DATA_WIDTH-1:0] r2_val_mem,
   input  logic [4:0]            mem_dst_reg,
   input  logic [31:0]           mem_opcode,
   input  logic [2:0]            mem_operation_size,
   input  logic                  ecall_mem,
   output logic                  dmem_req_valid,
   input  logic                  dmem_req_ready,
   output logic                  dmem_req_write,
   output logic [ADDR_WIDTH-1:0] dmem_req_addr,
   output logic [DATA_WIDTH-1:0] dmem_req_wdata,
   output logic [7:0]            dmem_req_wstrb,
   input  logic                  dmem_resp_valid,
   input  logic [DATA_WIDTH-1:0] dmem_resp_rdata,
   output logic                  wb_valid,
   input  logic                  next_stage_ready,
   output logic [4:0]            wb_dst_reg,
   output logic [DATA_WIDTH-1:0] wb_data,
   output logic                  wb_ecall,
   output logic                  misaligned
);

   // state  | meaning
   // IDLE   | no instruction held, accepting
   // REQ    | dmem request presented, waiting for dmem_req_ready
   // WAIT   | load issued, waiting for dmem_resp_valid
   // DONE   | writeback record presented, waiting for next_stage_ready
   typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

   state_t                state_q, state_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [DATA_WIDTH-1:0] sdata_q, sdata_d;
   logic [4:0]            dst_q, dst_d;
   logic [2:0]            size_q, size_d;
   logic                  store_q, store_d;
   logic                  ecall_q, ecall_d;
   logic                  mis_q, mis_d;
   logic [4:0]            wb_dst_q, wb_dst_d;
   logic [DATA_WIDTH-1:0] wb_data_q, wb_data_d;

   logic                  accept, in_req, in_load, in_store, in_mem, in_mis;
   logic [5:0]            shamt;
   logic [7:0]            base_strb;
   logic [DATA_WIDTH-1:0] rd_sh, ld_data;

   assign in_load  = (mem_opcode == 32'd1);
   assign in_store = (mem_opcode == 32'd2);
   assign in_mem   = in_load | in_store;

   always_comb begin
      case (mem_operation_size[1:0])
         2'd0:    in_mis = 1'b0;
         2'd1:    in_mis = ex_res[0];
         2'd2:    in_mis = |ex_res[1:0];
         default: in_mis = |ex_res[2:0];
      endcase
   end

   assign shamt = {addr_q[2:0], 3'b000};
   assign rd_sh = dmem_resp_rdata >> shamt;

   always_comb begin
      case (size_q[1:0])
         2'd0:    base_strb = 8'h01;
         2'd1:    base_strb = 8'h03;
         2'd2:    base_strb = 8'h0F;
         default: base_strb = 8'hFF;
      endcase
   end

   // size_q[2] selects zero extension; a dword load is never extended
   always_comb begin
      case (size_q[1:0])
         2'd0:    ld_data = size_q[2] ? {{(DATA_WIDTH-8){1'b0}}, rd_sh[7:0]}
                                      : {{(DATA_WIDTH-8){rd_sh[7]}}, rd_sh[7:0]};
         2'd1:    ld_data = size_q[2] ? {{(DATA_WIDTH-16){1'b0}}, rd_sh[15:0]}
                                      : {{(DATA_WIDTH-16){rd_sh[15]}}, rd_sh[15:0]};
         2'd2:    ld_data = size_q[2] ? {{(DATA_WIDTH-32){1'b0}}, rd_sh[31:0]}
                                      : {{(DATA_WIDTH-32){rd_sh[31]}}, rd_sh[31:0]};
         default: ld_data = rd_sh;
      endcase
   end

   assign in_req         = (state_q == S_REQ);
   assign dmem_req_valid = in_req;
   assign dmem_req_write = in_req & store_q;
   assign dmem_req_addr  = in_req ? {addr_q[ADDR_WIDTH-1:3], 3'b000} : '0;
   assign dmem_req_wdata = in_req ? (sdata_q << shamt) : '0;
   assign dmem_req_wstrb = in_req ? (base_strb << addr_q[2:0]) : '0;

   assign wb_valid   = (state_q == S_DONE);
   assign ready      = (state_q == S_IDLE) || ((state_q == S_DONE) && next_stage_ready);
   assign accept     = ex_valid & ready;
   assign wb_dst_reg = wb_dst_q;
   assign wb_data    = wb_data_q;
   assign wb_ecall   = ecall_q;
   assign misaligned = mis_q;

   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      sdata_d   = sdata_q;
      dst_d     = dst_q;
      size_d    = size_q;
      store_d   = store_q;
      ecall_d   = ecall_q;
      mis_d     = mis_q;
      wb_dst_d  = wb_dst_q;
      wb_data_d = wb_data_q;
      case (state_q)
         S_REQ: begin
            if (dmem_req_ready) begin
               if (store_q) begin
                  state_d   = S_DONE;
                  wb_dst_d  = '0;
                  wb_data_d = '0;
               end else begin
                  state_d = S_WAIT;
               end
            end
         end
         S_WAIT: begin
            if (dmem_resp_valid) begin
               state_d   = S_DONE;
               wb_dst_d  = dst_q;
               wb_data_d = ld_data;
            end
         end
         S_DONE: begin
            if (next_stage_ready) state_d = S_IDLE;
         end
         default: ;
      endcase
      // accept is only possible in IDLE or DONE, so it overrides the case above
      if (accept) begin
         addr_d  = ADDR_WIDTH'(ex_res);
         sdata_d = r2_val_mem;
         dst_d   = mem_dst_reg;
         size_d  = mem_operation_size;
         store_d = in_store;
         ecall_d = ecall_mem;
         mis_d   = in_mem & in_mis;
         if (!in_mem) begin
            state_d   = S_DONE;
            wb_dst_d  = mem_dst_reg;
            wb_data_d = ex_res;
         end else if (in_mis) begin
            state_d   = S_DONE;
            wb_dst_d  = '0;
            wb_data_d = '0;
         end else begin
            state_d = S_REQ;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= S_IDLE;
         addr_q    <= '0;
         sdata_q   <= '0;
         dst_q     <= '0;
         size_q    <= '0;
         store_q   <= 1'b0;
         ecall_q   <= 1'b0;
         mis_q     <= 1'b0;
         wb_dst_q  <= '0;
         wb_data_q <= '0;
      end else begin
         state_q   <= state_d;
         addr_q    <= addr_d;
         sdata_q   <= sdata_d;
         dst_q     <= dst_d;
         size_q    <= size_d;
         store_q   <= store_d;
         ecall_q   <= ecall_d;
         mis_q     <= mis_d;
         wb_dst_q  <= wb_dst_d;
         wb_data_q <= wb_data_d;
      end
   end

endmodule

// File: tb/tb_pipeline_mem.sv
// Bench for pipeline_mem: randomized instructions against a transaction-level model of
// the expected dmem request and writeback record, plus directed corner cases.
module tb_pipeline_mem;
   logic        clk = 1'b0;
   logic        reset;
   logic        ex_valid, ready;
   logic [63:0] ex_res, r2_val_mem;
   logic [4:0]  mem_dst_reg;
   logic [31:0] mem_opcode;
   logic [2:0]  mem_operation_size;
   logic        ecall_mem;
   logic        dmem_req_valid, dmem_req_ready, dmem_req_write;
   logic [63:0] dmem_req_addr, dmem_req_wdata;
   logic [7:0]  dmem_req_wstrb;
   logic        dmem_resp_valid;
   logic [63:0] dmem_resp_rdata;
   logic        wb_valid, next_stage_ready;
   logic [4:0]  wb_dst_reg;
   logic [63:0] wb_data;
   logic        wb_ecall, misaligned;

   pipeline_mem #(.ADDR_WIDTH(64), .DATA_WIDTH(64)) dut (
      .clk(clk), .reset(reset), .ex_valid(ex_valid), .ready(ready),
      .ex_res(ex_res), .r2_val_mem(r2_val_mem), .mem_dst_reg(mem_dst_reg),
      .mem_opcode(mem_opcode), .mem_operation_size(mem_operation_size),
      .ecall_mem(ecall_mem), .dmem_req_valid(dmem_req_valid),
      .dmem_req_ready(dmem_req_ready), .dmem_req_write(dmem_req_write),
      .dmem_req_addr(dmem_req_addr), .dmem_req_wdata(dmem_req_wdata),
      .dmem_req_wstrb(dmem_req_wstrb), .dmem_resp_valid(dmem_resp_valid),
      .dmem_resp_rdata(dmem_resp_rdata), .wb_valid(wb_valid),
      .next_stage_ready(next_stage_ready), .wb_dst_reg(wb_dst_reg),
      .wb_data(wb_data), .wb_ecall(wb_ecall), .misaligned(misaligned)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [4:0]  dst;
      logic [63:0] data;
      logic        ecall;
      logic        mis;
   } wb_t;

   wb_t         exp_q[$];
   int          n_checks = 0;
   int          n_fail = 0;
   bit          exp_req_ok = 0;
   logic [63:0] exp_req_addr, exp_req_wdata;
   logic [7:0]  exp_req_wstrb;
   logic        exp_req_write;
   bit          cur_mem, cur_load;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [63:0] model_load(logic [63:0] rdata, int off, int bytes, bit uns);
      logic [63:0] v, m;
      v = rdata >> (8 * off);
      if (bytes < 8) begin
         m = (64'd1 << (8 * bytes)) - 64'd1;
         v = v & m;
         if (!uns && v[8*bytes-1]) v = v | ~m;
      end
      return v;
   endfunction

   function automatic logic [7:0] model_strb(int off, int bytes);
      logic [15:0] s;
      s = ((16'd1 << bytes) - 16'd1) << off;
      return s[7:0];
   endfunction

   function automatic bit model_mis(logic [63:0] addr, int bytes);
      return (addr % 64'(bytes)) != 0;
   endfunction

   // one compare process: every request and every writeback record seen
   always @(negedge clk) begin
      if (!reset) begin
         if (dmem_req_valid) begin
            chk("spurious_req", 64'(exp_req_ok), 64'd1);
            chk("req_addr", dmem_req_addr, exp_req_addr);
            chk("req_wdata", dmem_req_wdata, exp_req_wdata);
            chk("req_wstrb", 64'(dmem_req_wstrb), 64'(exp_req_wstrb));
            chk("req_write", 64'(dmem_req_write), 64'(exp_req_write));
            chk("ready_in_req", 64'(ready), 64'd0);
         end
         if (wb_valid) begin
            if (exp_q.size() == 0) begin
               chk("wb_unexpected", 64'(exp_q.size()), 64'd1);
            end else begin
               chk("wb_dst", 64'(wb_dst_reg), 64'(exp_q[0].dst));
               chk("wb_data", wb_data, exp_q[0].data);
               chk("wb_ecall", 64'(wb_ecall), 64'(exp_q[0].ecall));
               chk("wb_mis", 64'(misaligned), 64'(exp_q[0].mis));
               chk("ready_in_done", 64'(ready), 64'(next_stage_ready));
               if (next_stage_ready) void'(exp_q.pop_front());
            end
         end
      end
   end

   task automatic scramble();
      ex_res             = {$urandom, $urandom};
      r2_val_mem         = {$urandom, $urandom};
      mem_dst_reg        = 5'($urandom);
      mem_opcode         = $urandom;
      mem_operation_size = 3'($urandom);
      ecall_mem          = 1'($urandom);
   endtask

   task automatic issue(input logic [31:0] op, input logic [63:0] addr, input logic [63:0] r2,
                        input logic [4:0] dst, input logic [2:0] size, input logic ecall,
                        input logic [63:0] rdata, input int req_stall);
      int  bytes, off;
      bit  is_ld, is_st, mis;
      wb_t w;
      bytes    = 1 << size[1:0];
      off      = int'(addr % 64'd8);
      is_ld    = (op == 32'd1);
      is_st    = (op == 32'd2);
      mis      = (is_ld || is_st) && model_mis(addr, bytes);
      cur_mem  = (is_ld || is_st) && !mis;
      cur_load = is_ld && !mis;
      w.ecall  = ecall;
      w.mis    = mis;
      if (!(is_ld || is_st)) begin
         w.dst  = dst;
         w.data = addr;
      end else if (mis || is_st) begin
         w.dst  = 5'd0;
         w.data = 64'd0;
      end else begin
         w.dst  = dst;
         w.data = model_load(rdata, off, bytes, size[2]);
      end
      exp_q.push_back(w);
      exp_req_addr  = addr & ~64'd7;
      exp_req_wdata = r2 << (8 * off);
      exp_req_wstrb = model_strb(off, bytes);
      exp_req_write = is_st;
      exp_req_ok    = cur_mem;
      chk("ready_idle", 64'(ready), 64'd1);
      ex_valid = 1'b1; ex_res = addr; r2_val_mem = r2; mem_dst_reg = dst;
      mem_opcode = op; mem_operation_size = size; ecall_mem = ecall;
      next_stage_ready = 1'b0;
      @(posedge clk) #1;
      ex_valid = 1'b0;
      scramble();
      if (!cur_mem) begin
         chk("wb_lat_nonmem", 64'(wb_valid), 64'd1);
         chk("no_req", 64'(dmem_req_valid), 64'd0);
         return;
      end
      for (int i = 0; i < req_stall; i++) begin
         chk("req_held", 64'(dmem_req_valid), 64'd1);
         chk("no_wb_in_req", 64'(wb_valid), 64'd0);
         @(posedge clk) #1;
      end
      dmem_req_ready = 1'b1;
      chk("req_held", 64'(dmem_req_valid), 64'd1);
      @(posedge clk) #1;
      dmem_req_ready = 1'b0;
      exp_req_ok = 0;
      if (!cur_load) chk("wb_lat_store", 64'(wb_valid), 64'd1);
   endtask

   task automatic run_instr(input logic [31:0] op, input logic [63:0] addr, input logic [63:0] r2,
                            input logic [4:0] dst, input logic [2:0] size, input logic ecall,
                            input logic [63:0] rdata, input int req_stall, input int resp_delay,
                            input int wb_stall);
      issue(op, addr, r2, dst, size, ecall, rdata, req_stall);
      if (cur_load) begin
         for (int i = 0; i < resp_delay; i++) begin
            chk("no_wb_in_wait", 64'(wb_valid), 64'd0);
            chk("no_req_in_wait", 64'(dmem_req_valid), 64'd0);
            chk("ready_in_wait", 64'(ready), 64'd0);
            @(posedge clk) #1;
         end
         dmem_resp_valid = 1'b1;
         dmem_resp_rdata = rdata;
         @(posedge clk) #1;
         dmem_resp_valid = 1'b0;
         dmem_resp_rdata = {$urandom, $urandom};
         chk("wb_lat_load", 64'(wb_valid), 64'd1);
      end
      for (int i = 0; i < wb_stall; i++) begin
         chk("done_hold", 64'(wb_valid), 64'd1);
         chk("ready_stall", 64'(ready), 64'd0);
         @(posedge clk) #1;
      end
      next_stage_ready = 1'b1;
      @(posedge clk) #1;
      next_stage_ready = 1'b0;
      chk("idle_after_wb", 64'(wb_valid), 64'd0);
      dmem_resp_valid = 1'b1;
      @(posedge clk) #1;
      dmem_resp_valid = 1'b0;
      chk("resp_ignored_idle", 64'(wb_valid), 64'd0);
   endtask

   task automatic back_to_back(input int n);
      wb_t w;
      next_stage_ready = 1'b1;
      for (int k = 0; k < n; k++) begin
         chk("b2b_ready", 64'(ready), 64'd1);
         ex_valid = 1'b1;
         ex_res = (k == 0) ? 64'h1234 : {$urandom, $urandom};
         mem_dst_reg = (k == 0) ? 5'd5 : 5'($urandom);
         mem_opcode = (k % 3 == 2) ? 32'd9 : 32'd0;
         ecall_mem = 1'($urandom);
         r2_val_mem = {$urandom, $urandom};
         mem_operation_size = 3'($urandom);
         w.dst = mem_dst_reg; w.data = ex_res; w.ecall = ecall_mem; w.mis = 1'b0;
         exp_q.push_back(w);
         @(posedge clk) #1;
         chk("b2b_no_bubble", 64'(wb_valid), 64'd1);
         if (k == 0) begin
            chk("lit_wb_1234", wb_data, 64'h1234);
            chk("lit_wb_dst5", 64'(wb_dst_reg), 64'd5);
         end
      end
      ex_valid = 1'b0;
      @(posedge clk) #1;
      next_stage_ready = 1'b0;
      chk("b2b_drain", 64'(wb_valid), 64'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: bench did not finish, got running expected done");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] op;
      logic [63:0] a;
      logic [2:0]  sz;
      reset = 1'b1; ex_valid = 1'b0; dmem_req_ready = 1'b0; dmem_resp_valid = 1'b0;
      next_stage_ready = 1'b0; dmem_resp_rdata = '0;
      scramble();
      #12;
      chk("rst_ready", 64'(ready), 64'd1);
      chk("rst_req_valid", 64'(dmem_req_valid), 64'd0);
      chk("rst_wb_valid", 64'(wb_valid), 64'd0);
      chk("rst_wb_data", wb_data, 64'd0);
      chk("rst_req_addr", dmem_req_addr, 64'd0);
      @(posedge clk) #1;
      reset = 1'b0;
      @(posedge clk) #1;

      // literal pins on the model itself
      chk("lit_model_lb", model_load(64'h00000000_80000000, 3, 1, 1'b0), 64'hFFFF_FFFF_FFFF_FF80);
      chk("lit_model_lbu", model_load(64'h00000000_80000000, 3, 1, 1'b1), 64'h80);
      chk("lit_model_strb", 64'(model_strb(6, 2)), 64'hC0);
      chk("lit_model_mis", 64'(model_mis(64'h3002, 4)), 64'd1);

      back_to_back(6);

      run_instr(32'd1, 64'h1003, 64'd0, 5'd3, 3'b000, 1'b0, 64'h00000000_80000000, 0, 2, 0);
      chk("lit_req_addr", exp_req_addr, 64'h1000);
      run_instr(32'd1, 64'h1003, 64'd0, 5'd4, 3'b100, 1'b0, 64'h00000000_80000000, 1, 0, 0);
      run_instr(32'd2, 64'h2006, 64'hABCD, 5'd6, 3'b001, 1'b0, 64'd0, 3, 0, 1);
      chk("lit_req_wdata", exp_req_wdata, 64'hABCD_0000_0000_0000);
      run_instr(32'd1, 64'h3002, 64'd0, 5'd7, 3'b010, 1'b1, 64'd0, 0, 0, 0);
      run_instr(32'd0, 64'h55, 64'd0, 5'd8, 3'b000, 1'b1, 64'd0, 0, 0, 5);

      for (int n = 0; n < 40; n++) begin
         case ($urandom_range(0, 3))
            0: op = 32'd0;
            1: op = 32'd1;
            2: op = 32'd2;
            default: op = 32'd3 + $urandom_range(0, 1000);
         endcase
         sz = 3'($urandom);
         a = {$urandom, $urandom};
         if ($urandom_range(0, 3) != 0) a = a & ~((64'd1 << sz[1:0]) - 64'd1);
         run_instr(op, a, {$urandom, $urandom}, 5'($urandom), sz, 1'($urandom),
                   {$urandom, $urandom}, $urandom_range(0, 3), $urandom_range(0, 3),
                   $urandom_range(0, 3));
      end

      // reset during WAIT abandons the load
      run_instr(32'd0, 64'hDEAD, 64'd0, 5'd9, 3'b000, 1'b1, 64'd0, 0, 0, 0);
      issue(32'd1, 64'h4008, 64'd0, 5'd7, 3'b011, 1'b0, 64'h1111, 0);
      @(posedge clk) #1;
      chk("in_wait_ready", 64'(ready), 64'd0);
      #2;
      reset = 1'b1;
      #1;
      exp_q.delete();
      chk("rstw_ready", 64'(ready), 64'd1);
      chk("rstw_req_valid", 64'(dmem_req_valid), 64'd0);
      chk("rstw_wb_valid", 64'(wb_valid), 64'd0);
      chk("rstw_wb_dst", 64'(wb_dst_reg), 64'd0);
      chk("rstw_wb_data", wb_data, 64'd0);
      chk("rstw_wb_ecall", 64'(wb_ecall), 64'd0);
      chk("rstw_mis", 64'(misaligned), 64'd0);
      chk("rstw_req_fields", {dmem_req_addr[31:0], dmem_req_wdata[15:0], dmem_req_wstrb, 7'd0, dmem_req_write}, 64'd0);
      @(posedge clk) #1;
      reset = 1'b0;
      dmem_resp_valid = 1'b1;
      dmem_resp_rdata = 64'h1111;
      @(posedge clk) #1;
      dmem_resp_valid = 1'b0;
      chk("late_resp_ignored", 64'(wb_valid), 64'd0);
      chk("late_resp_ready", 64'(ready), 64'd1);
      @(posedge clk) #1;
      chk("late_resp_idle", 64'(wb_valid), 64'd0);

      run_instr(32'd2, 64'h5001, 64'h77, 5'd2, 3'b000, 1'b0, 64'd0, 2, 0, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
